// File: rtl/sevenseg_capture.sv
// -----------------------------------------------------------------------------
// sevenseg_capture
// Receiving end of a quad seven-segment scan interface. Samples the multiplexed
// active-low anode/cathode lines, waits for each digit strobe to settle,
// decodes the segment pattern into a digit value, and publishes all four digits
// as one coherent frame once every digit has been seen.
//
// Optional feature macro: SEVENSEG_CAPTURE_HEX_EN
//   defined   -> hex glyphs A,b,C,d,E,F also decode cleanly (values 4'hA..4'hF)
//   undefined -> only 0-9 decode; every other pattern is flagged as an error
//
// Ports:
//   clk          in   1  system clock (5 MHz)
//   reset        in   1  asynchronous, active-high reset
//   cathodes_in  in   7  active-low segments, bit0=a .. bit6=g
//   anodes_in    in   8  active-low digit enables, bit n = digit n
//   digit0..3    out  4  published digit values (digit0 rightmost)
//   digit_err    out  4  per-digit flag: published pattern was undecodable
//   frame_valid  out  1  one-clock pulse when digit0..3/digit_err update
//   stale        out  1  high while no capture has completed for TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module sevenseg_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int SETTLE_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] cathodes_in,
  input  logic [7:0] anodes_in,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       stale
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [SETTLE_WIDTH-1:0]  LP_SETTLE_ONE = SETTLE_WIDTH'(1);
  localparam logic [SETTLE_WIDTH-1:0]  LP_SETTLE_MAX = SETTLE_WIDTH'(SETTLE_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_TO_MAX     = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  // Returns {err, value}; undecodable patterns give value 4'hF with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = {1'b0, 4'h0};
      7'h79:   res = {1'b0, 4'h1};
      7'h24:   res = {1'b0, 4'h2};
      7'h30:   res = {1'b0, 4'h3};
      7'h19:   res = {1'b0, 4'h4};
      7'h12:   res = {1'b0, 4'h5};
      7'h02:   res = {1'b0, 4'h6};
      7'h78:   res = {1'b0, 4'h7};
      7'h00:   res = {1'b0, 4'h8};
      7'h10:   res = {1'b0, 4'h9};
`ifdef SEVENSEG_CAPTURE_HEX_EN
      7'h08:   res = {1'b0, 4'hA};
      7'h03:   res = {1'b0, 4'hB};
      7'h46:   res = {1'b0, 4'hC};
      7'h21:   res = {1'b0, 4'hD};
      7'h06:   res = {1'b0, 4'hE};
      7'h0E:   res = {1'b0, 4'hF};
`endif
      default: res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  state_t                   r_state;
  state_t                   w_next_state;
  logic [7:0]               r_an;
  logic [6:0]               r_cat;
  logic [7:0]               r_an_lat;
  logic [6:0]               r_cat_lat;
  logic [SETTLE_WIDTH-1:0]  r_settle_cnt;
  logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
  logic [TIMEOUT_WIDTH-1:0] w_to_next;
  logic [3:0]               r_seen;
  logic [3:0][3:0]          r_shadow_val;
  logic [3:0]               r_shadow_err;
  logic [3:0][3:0]          r_digit;
  logic [3:0]               r_digit_err;
  logic                     r_frame_valid;
  logic                     r_stale;
  logic                     w_strobe_valid;
  logic [1:0]               w_idx;
  logic                     w_same;
  logic                     w_load;
  logic                     w_capture;
  logic [4:0]               w_dec;

  assign digit0      = r_digit[0];
  assign digit1      = r_digit[1];
  assign digit2      = r_digit[2];
  assign digit3      = r_digit[3];
  assign digit_err   = r_digit_err;
  assign frame_valid = r_frame_valid;
  assign stale       = r_stale;

  assign w_same = (r_an == r_an_lat) && (r_cat == r_cat_lat);
  assign w_dec  = decode_seg(r_cat);

  // Strobe qualification: exactly one of the low four anodes active, upper four idle.
  always_comb begin
    w_strobe_valid = 1'b0;
    w_idx          = 2'd0;
    if (r_an[7:4] == 4'hF) begin
      case (r_an[3:0])
        4'b1110: begin w_strobe_valid = 1'b1; w_idx = 2'd0; end
        4'b1101: begin w_strobe_valid = 1'b1; w_idx = 2'd1; end
        4'b1011: begin w_strobe_valid = 1'b1; w_idx = 2'd2; end
        4'b0111: begin w_strobe_valid = 1'b1; w_idx = 2'd3; end
        default: begin w_strobe_valid = 1'b0; w_idx = 2'd0; end
      endcase
    end else begin
      w_strobe_valid = 1'b0;
    end
  end

  // Capture FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_strobe_valid) begin
          w_load       = 1'b1;
          w_next_state = S_SETTLE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_SETTLE: begin
        if (!w_same || !w_strobe_valid) begin
          w_next_state = S_WAIT;
        end else if (r_settle_cnt == LP_SETTLE_MAX) begin
          w_capture    = 1'b1;
          w_next_state = S_HOLD;
        end else begin
          w_next_state = S_SETTLE;
        end
      end
      S_HOLD: begin
        // One capture per strobe: wait for the anode pattern to move on.
        if (r_an != r_an_lat) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_HOLD;
        end
      end
      default: w_next_state = S_WAIT;
    endcase
  end

  // Input sampling register and the pattern latched at strobe start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an      <= 8'hFF;
      r_cat     <= 7'h7F;
      r_an_lat  <= 8'hFF;
      r_cat_lat <= 7'h7F;
    end else begin
      r_an  <= anodes_in;
      r_cat <= cathodes_in;
      if (w_load) begin
        r_an_lat  <= r_an;
        r_cat_lat <= r_cat;
      end
    end
  end

  // FSM state register and settle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT;
      r_settle_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_settle_cnt <= LP_SETTLE_ONE;
      end else if (r_state == S_SETTLE && w_next_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + LP_SETTLE_ONE;
      end else begin
        r_settle_cnt <= '0;
      end
    end
  end

  // Shadow registers and seen mask; a full mask is cleared as it is published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen       <= 4'h0;
      r_shadow_val <= '0;
      r_shadow_err <= 4'h0;
    end else if (r_seen == 4'hF) begin
      r_seen <= 4'h0;
    end else if (w_capture) begin
      r_shadow_val[w_idx] <= w_dec[3:0];
      r_shadow_err[w_idx] <= w_dec[4];
      r_seen[w_idx]       <= 1'b1;
    end
  end

  // Frame publication: copy shadows the clock after the mask completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit       <= '0;
      r_digit_err   <= 4'h0;
      r_frame_valid <= 1'b0;
    end else if (r_seen == 4'hF) begin
      r_digit       <= r_shadow_val;
      r_digit_err   <= r_shadow_err;
      r_frame_valid <= 1'b1;
    end else begin
      r_frame_valid <= 1'b0;
    end
  end

  assign w_to_next = w_capture ? '0 :
                     (r_to_cnt == LP_TO_MAX) ? LP_TO_MAX : r_to_cnt + TIMEOUT_WIDTH'(1);

  // Saturating timeout counter; stale mirrors the saturated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else begin
      r_to_cnt <= w_to_next;
      r_stale  <= (w_to_next == LP_TO_MAX);
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
module tb_sevenseg_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] cathodes_in;
  logic [7:0] anodes_in;
  logic [3:0] digit0, digit1, digit2, digit3, digit_err;
  logic       frame_valid, stale;

  sevenseg_capture dut (
    .clk(clk), .reset(reset), .cathodes_in(cathodes_in), .anodes_in(anodes_in),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit_err(digit_err), .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;

  // Glyph table: index = value.  Entries 10..15 are the hex letters.
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEVENSEG_CAPTURE_HEX_EN
  int n_dec = 16;
`else
  int n_dec = 10;
`endif

  // Reference model state
  int m_val [4];
  bit m_err [4];
  bit m_seen[4];
  int exp_d [4];
  bit exp_e [4];
  int exp_frames = 0;
  bit exp_stale  = 1'b0;

  // Count frame_valid high cycles, sampled away from the active edge.
  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_decode(input logic [6:0] seg, output int v, output bit e);
    v = 15;
    e = 1'b1;
    for (int i = 0; i < n_dec; i++) begin
      if (glyph_tab[i] == seg) begin
        v = i;
        e = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_err[i] = 1'b0; m_seen[i] = 1'b0;
      exp_d[i] = 0; exp_e[i] = 1'b0;
    end
    exp_stale = 1'b0;
  endfunction

  // Drive one strobe of len clocks followed by a blank gap, and update the model.
  task automatic strobe(input logic [7:0] a, input logic [6:0] c, input int len);
    logic [3:0] lo;
    int idx, v;
    bit e, all;
    @(negedge clk);
    anodes_in = a; cathodes_in = c;
    repeat (len) @(negedge clk);
    anodes_in = 8'hFF; cathodes_in = 7'h7F;
    repeat (4) @(negedge clk);
    lo = ~a[3:0];
    if (a[7:4] == 4'hF && $countones(lo) == 1 && len >= 22) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (lo[i]) idx = i;
      model_decode(c, v, e);
      m_val[idx] = v; m_err[idx] = e; m_seen[idx] = 1'b1;
      exp_stale = 1'b0;
      all = m_seen[0] & m_seen[1] & m_seen[2] & m_seen[3];
      if (all) begin
        for (int i = 0; i < 4; i++) begin
          exp_d[i] = m_val[i]; exp_e[i] = m_err[i]; m_seen[i] = 1'b0;
        end
        exp_frames++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.d0", tag), 32'(digit0), 32'(exp_d[0]));
    chk($sformatf("%s.d1", tag), 32'(digit1), 32'(exp_d[1]));
    chk($sformatf("%s.d2", tag), 32'(digit2), 32'(exp_d[2]));
    chk($sformatf("%s.d3", tag), 32'(digit3), 32'(exp_d[3]));
    chk($sformatf("%s.err", tag), 32'(digit_err), 32'({exp_e[3], exp_e[2], exp_e[1], exp_e[0]}));
    chk($sformatf("%s.frames", tag), 32'(fv_cnt), 32'(exp_frames));
    chk($sformatf("%s.stale", tag), 32'(stale), 32'(exp_stale));
  endtask

  initial begin
    logic [7:0] an_pick;
    logic [6:0] cat_pick;
    logic [7:0] bad_an [5] = '{8'hFC, 8'hEF, 8'h00, 8'hF0, 8'h7E};
    logic [3:0] hex_exp;
    logic [3:0] hex_err;
    int r;

    reset = 1'b1; anodes_in = 8'hFF; cathodes_in = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // "12:34" scan
    strobe(8'hFE, glyph_tab[4], 30);
    strobe(8'hFD, glyph_tab[3], 30);
    strobe(8'hFB, glyph_tab[2], 30);
    strobe(8'hF7, glyph_tab[1], 30);
    check_all("scan1234");
    chk("scan.d3", 32'(digit3), 32'd1);
    chk("scan.d0", 32'(digit0), 32'd4);
    chk("scan.fv", 32'(fv_cnt), 32'd1);

    // Glitch shorter than the settle window, then a full strobe
    strobe(8'hFE, glyph_tab[7], 10);
    check_all("glitch");
    strobe(8'hFE, glyph_tab[7], 30);
    // Digit 1 strobed twice before the frame completes
    strobe(8'hFD, glyph_tab[7], 30);
    strobe(8'hFD, glyph_tab[9], 30);
    check_all("repeat_partial");
    strobe(8'hFB, glyph_tab[5], 30);
    strobe(8'hF7, glyph_tab[6], 30);
    check_all("repeat");
    chk("repeat.d1", 32'(digit1), 32'd9);
    chk("repeat.fv", 32'(fv_cnt), 32'd2);

    // Invalid strobes must not set seen bits; blank digit decodes as error
    strobe(8'hFC, glyph_tab[5], 30);
    strobe(8'hEF, glyph_tab[5], 30);
    strobe(8'hFE, glyph_tab[0], 30);
    strobe(8'hFD, glyph_tab[8], 30);
    strobe(8'hF7, glyph_tab[3], 30);
    check_all("invalid_partial");
    strobe(8'hFB, 7'h7F, 30);
    check_all("blank");
    chk("blank.d2", 32'(digit2), 32'hF);
    chk("blank.err", 32'(digit_err), 32'b0100);

    // Randomized strobes
    for (int n = 0; n < 48; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       cat_pick = glyph_tab[$urandom_range(0, 15)];
      else if (r == 8) cat_pick = 7'h7F;
      else             cat_pick = 7'($urandom_range(0, 127));
      r = $urandom_range(0, 9);
      if (r == 0) an_pick = bad_an[$urandom_range(0, 4)];
      else        an_pick = ~(8'h01 << $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) strobe(an_pick, cat_pick, $urandom_range(2, 10));
      else                           strobe(an_pick, cat_pick, $urandom_range(22, 40));
      check_all($sformatf("rand%0d", n));
    end

    // Timeout: idle anodes
    repeat (49000) @(negedge clk);
    chk("stale.early", 32'(stale), 32'd0);
    repeat (11000) @(negedge clk);
    exp_stale = 1'b1;
    check_all("stale");
    strobe(8'hFE, glyph_tab[2], 30);
    check_all("stale_clear");

    // Reset mid-frame
    strobe(8'hFE, glyph_tab[5], 30);
    strobe(8'hFD, glyph_tab[6], 30);
    #1 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    chk("async_reset.d0", 32'(digit0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    strobe(8'hFE, glyph_tab[1], 30);
    strobe(8'hFD, glyph_tab[2], 30);
    strobe(8'hFB, glyph_tab[3], 30);
    check_all("post_reset_partial");
    strobe(8'hF7, glyph_tab[4], 30);
    check_all("post_reset_frame");

    // Hex glyph A on every digit
`ifdef SEVENSEG_CAPTURE_HEX_EN
    hex_exp = 4'hA; hex_err = 4'h0;
`else
    hex_exp = 4'hF; hex_err = 4'hF;
`endif
    for (int i = 0; i < 4; i++) strobe(~(8'h01 << i), 7'h08, 30);
    check_all("hex");
    chk("hex.d3", 32'(digit3), 32'(hex_exp));
    chk("hex.err", 32'(digit_err), 32'(hex_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
